// File: rtl/riscv_pkg.sv
// Shared core definitions: reset PC and the PC-file sequencing states.
// Pure declarations; no timing or flow control.
package riscv_pkg;

   localparam logic [31:0] STARTUP_ADDR = 32'h0000_0000;

   typedef enum logic [1:0] {
      PCF_INIT,
      PCF_WARMUP,
      PCF_RUN
   } pcf_state_t;

endpackage

// File: rtl/LUT_RAM.sv
// Distributed RAM: synchronous write, asynchronous read, no reset on contents.
// Read data follows raddr combinationally; no backpressure.
module LUT_RAM #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pc_file_mt.sv
// Per-thread PC store with init sweep, warm-up write-back gating and halt/resume.
// Read is combinational with write-first bypass; one write per cycle (init > resume > wb), no backpressure.
module pc_file_mt #(
   parameter int                DWIDTH       = 32,
   parameter int                PC_BITS      = 12,
   parameter int                NUM_THREADS  = 16,
   parameter int                EXE_STAGE    = 7,
   parameter logic [DWIDTH-1:0] STARTUP_ADDR = riscv_pkg::STARTUP_ADDR,
   localparam int               TW           = $clog2(NUM_THREADS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [TW-1:0]          i_thread_index_counter,
   output logic [DWIDTH-1:0]      o_pcreg_out,
   output logic                   o_thread_active,
   output logic                   o_ready,
   input  logic                   i_wb_valid,
   input  logic [TW-1:0]          i_wb_thread,
   input  logic [DWIDTH-1:0]      i_pc_in,
   input  logic                   i_halt_valid,
   input  logic [TW-1:0]          i_halt_thread,
   input  logic                   i_resume_valid,
   input  logic [TW-1:0]          i_resume_thread,
   input  logic [DWIDTH-1:0]      i_resume_pc,
   output logic [NUM_THREADS-1:0] o_halted_mask
);

   import riscv_pkg::*;

   localparam logic [TW:0] WARM_LEN = (TW+1)'(EXE_STAGE + 1);

   pcf_state_t             state, state_nxt;
   logic [TW-1:0]          init_ptr, init_ptr_nxt;
   logic [TW:0]            warm_cnt, warm_cnt_nxt;
   logic [NUM_THREADS-1:0] halted, halted_nxt;

   logic                   we;
   logic                   wb_ok;
   logic [TW-1:0]          waddr;
   logic [PC_BITS-1:0]     wdata;
   logic [PC_BITS-1:0]     ram_rdata;
   logic [PC_BITS-1:0]     rd_pc;
   logic                   unused_hi;

   assign unused_hi = ^{i_pc_in, i_resume_pc};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= PCF_INIT;
         init_ptr <= '0;
         warm_cnt <= '0;
         halted   <= '0;
      end else begin
         state    <= state_nxt;
         init_ptr <= init_ptr_nxt;
         warm_cnt <= warm_cnt_nxt;
         halted   <= halted_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      init_ptr_nxt = init_ptr;
      warm_cnt_nxt = warm_cnt;
      halted_nxt   = halted;
      case (state)
         PCF_INIT: begin
            init_ptr_nxt = init_ptr + 1'b1;
            if (init_ptr == TW'(NUM_THREADS - 1)) state_nxt = PCF_WARMUP;
         end
         PCF_WARMUP: begin
            warm_cnt_nxt = warm_cnt + 1'b1;
            if (warm_cnt_nxt == WARM_LEN) state_nxt = PCF_RUN;
         end
         default: ;
      endcase
      // Resume is applied after halt so it wins on the same thread.
      if (state != PCF_INIT) begin
         if (i_halt_valid)   halted_nxt[i_halt_thread]   = 1'b1;
         if (i_resume_valid) halted_nxt[i_resume_thread] = 1'b0;
      end
   end

   always_comb begin
      wb_ok = (state == PCF_RUN) && i_wb_valid && !halted[i_wb_thread] &&
              !(i_halt_valid && (i_halt_thread == i_wb_thread)) && !i_resume_valid;
      we    = 1'b0;
      waddr = init_ptr;
      wdata = STARTUP_ADDR[PC_BITS-1:0];
      if (state == PCF_INIT) begin
         we = 1'b1;
      end else if (i_resume_valid) begin
         we    = 1'b1;
         waddr = i_resume_thread;
         wdata = i_resume_pc[PC_BITS-1:0];
      end else if (wb_ok) begin
         we    = 1'b1;
         waddr = i_wb_thread;
         wdata = i_pc_in[PC_BITS-1:0];
      end
   end

   LUT_RAM #(
      .DEPTH      (NUM_THREADS),
      .ADDR_WIDTH (TW),
      .DATA_WIDTH (PC_BITS)
   ) u_pc_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (i_thread_index_counter),
      .rdata (ram_rdata)
   );

   assign rd_pc           = (we && (waddr == i_thread_index_counter)) ? wdata : ram_rdata;
   assign o_pcreg_out     = DWIDTH'(rd_pc);
   assign o_ready         = (state != PCF_INIT);
   assign o_thread_active = o_ready && !halted[i_thread_index_counter];
   assign o_halted_mask   = halted;

endmodule

// File: tb/tb_pc_file_mt.sv
// Bench for pc_file_mt: scoreboard of expected outputs, drained at the falling edge.
module tb_pc_file_mt;

   localparam int SEL_PC   = 0;
   localparam int SEL_ACT  = 1;
   localparam int SEL_RDY  = 2;
   localparam int SEL_MASK = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  i_thread_index_counter;
   logic [31:0] o_pcreg_out;
   logic        o_thread_active;
   logic        o_ready;
   logic        i_wb_valid;
   logic [3:0]  i_wb_thread;
   logic [31:0] i_pc_in;
   logic        i_halt_valid;
   logic [3:0]  i_halt_thread;
   logic        i_resume_valid;
   logic [3:0]  i_resume_thread;
   logic [31:0] i_resume_pc;
   logic [15:0] o_halted_mask;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_t;

   sb_t         sb_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [11:0] mdl_pc [16];
   logic [15:0] mdl_mask;

   pc_file_mt dut (
      .clk                    (clk),
      .reset                  (reset),
      .i_thread_index_counter (i_thread_index_counter),
      .o_pcreg_out            (o_pcreg_out),
      .o_thread_active        (o_thread_active),
      .o_ready                (o_ready),
      .i_wb_valid             (i_wb_valid),
      .i_wb_thread            (i_wb_thread),
      .i_pc_in                (i_pc_in),
      .i_halt_valid           (i_halt_valid),
      .i_halt_thread          (i_halt_thread),
      .i_resume_valid         (i_resume_valid),
      .i_resume_thread        (i_resume_thread),
      .i_resume_pc            (i_resume_pc),
      .o_halted_mask          (o_halted_mask)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int sel, input logic [31:0] exp);
      sb_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      sb_t         e;
      logic [31:0] obs;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.sel)
            SEL_PC:   obs = o_pcreg_out;
            SEL_ACT:  obs = {31'd0, o_thread_active};
            SEL_RDY:  obs = {31'd0, o_ready};
            default:  obs = {16'd0, o_halted_mask};
         endcase
         check_val(e.tag, obs, e.exp);
      end
   endtask

   // Check at the falling edge, then let one rising edge pass.
   task automatic cyc();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_wb_valid     = 1'b0;
      i_halt_valid   = 1'b0;
      i_resume_valid = 1'b0;
   endtask

   task automatic drive_wb(input logic [3:0] t, input logic [31:0] pc);
      i_wb_valid  = 1'b1;
      i_wb_thread = t;
      i_pc_in     = pc;
   endtask

   task automatic drive_halt(input logic [3:0] t);
      i_halt_valid  = 1'b1;
      i_halt_thread = t;
   endtask

   task automatic drive_resume(input logic [3:0] t, input logic [31:0] pc);
      i_resume_valid  = 1'b1;
      i_resume_thread = t;
      i_resume_pc     = pc;
   endtask

   task automatic sweep(input string tag);
      for (int t = 0; t < 16; t++) begin
         i_thread_index_counter = 4'(t);
         push($sformatf("%s_pc%0d", tag, t), SEL_PC, {20'd0, mdl_pc[t]});
         push($sformatf("%s_act%0d", tag, t), SEL_ACT, {31'd0, !mdl_mask[t]});
         cyc();
      end
   endtask

   task automatic init_phase(input string tag);
      for (int i = 0; i < 16; i++) begin
         push($sformatf("%s_rdy%0d", tag, i), SEL_RDY, 32'd0);
         cyc();
      end
   endtask

   initial begin
      idle();
      i_wb_thread = '0;  i_pc_in = '0;  i_halt_thread = '0;
      i_resume_thread = '0;  i_resume_pc = '0;
      i_thread_index_counter = '0;
      for (int t = 0; t < 16; t++) mdl_pc[t] = 12'h000;
      mdl_mask = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      push("rst_mask", SEL_MASK, 32'd0);
      push("rst_act", SEL_ACT, 32'd0);
      init_phase("init");

      // Warm-up cycle 0: ready must already be up.
      push("ready_up", SEL_RDY, 32'd1);
      cyc();
      cyc();
      cyc();
      i_thread_index_counter = 4'd5;
      drive_wb(4'd5, 32'h0000_0ABC);
      push("warm_wb_nobypass", SEL_PC, 32'd0);
      cyc();
      idle();
      push("warm_wb_dropped", SEL_PC, 32'd0);
      cyc();
      cyc();
      cyc();
      // Last warm-up cycle: write-back still gated.
      drive_wb(4'd6, 32'h0000_0555);
      cyc();
      idle();
      // First run cycle: write-back now honoured.
      i_thread_index_counter = 4'd6;
      push("last_warm_dropped", SEL_PC, 32'd0);
      drive_wb(4'd5, 32'h0000_0ABC);
      cyc();
      idle();
      mdl_pc[5] = 12'hABC;
      sweep("run");

      drive_wb(4'd5, 32'hFFFF_F123);
      cyc();
      idle();
      mdl_pc[5] = 12'h123;
      i_thread_index_counter = 4'd5;
      push("trunc_pc", SEL_PC, 32'h0000_0123);
      cyc();

      i_thread_index_counter = 4'd9;
      drive_wb(4'd9, 32'h0000_0444);
      push("bypass_same", SEL_PC, 32'h0000_0444);
      cyc();
      idle();
      mdl_pc[9] = 12'h444;
      push("bypass_stored", SEL_PC, 32'h0000_0444);
      cyc();

      drive_halt(4'd3);
      cyc();
      idle();
      mdl_mask[3] = 1'b1;
      i_thread_index_counter = 4'd3;
      push("halt3_mask", SEL_MASK, {16'd0, mdl_mask});
      push("halt3_act", SEL_ACT, 32'd0);
      push("halt3_pc", SEL_PC, 32'd0);
      cyc();
      drive_wb(4'd3, 32'h0000_0100);
      push("halted_wb_nobypass", SEL_PC, 32'd0);
      cyc();
      idle();
      push("halted_wb_dropped", SEL_PC, 32'd0);
      cyc();
      drive_resume(4'd3, 32'h0000_0200);
      push("resume_bypass", SEL_PC, 32'h0000_0200);
      cyc();
      idle();
      mdl_mask[3] = 1'b0;
      mdl_pc[3]   = 12'h200;
      push("resume3_mask", SEL_MASK, 32'd0);
      push("resume3_act", SEL_ACT, 32'd1);
      push("resume3_pc", SEL_PC, 32'h0000_0200);
      cyc();

      drive_halt(4'd7);
      drive_resume(4'd7, 32'h0000_00F0);
      cyc();
      idle();
      mdl_pc[7] = 12'h0F0;
      i_thread_index_counter = 4'd7;
      push("halt_res7_mask", SEL_MASK, 32'd0);
      push("halt_res7_pc", SEL_PC, 32'h0000_00F0);
      cyc();

      drive_resume(4'd2, 32'h0000_0010);
      drive_wb(4'd4, 32'h0000_0020);
      cyc();
      idle();
      mdl_pc[2] = 12'h010;
      i_thread_index_counter = 4'd2;
      push("res_vs_wb_res", SEL_PC, 32'h0000_0010);
      cyc();
      i_thread_index_counter = 4'd4;
      push("res_vs_wb_wb", SEL_PC, {20'd0, mdl_pc[4]});
      cyc();

      drive_halt(4'd10);
      drive_wb(4'd10, 32'h0000_0077);
      cyc();
      idle();
      mdl_mask[10] = 1'b1;
      i_thread_index_counter = 4'd10;
      push("halt_wb10_pc", SEL_PC, 32'd0);
      push("halt_wb10_act", SEL_ACT, 32'd0);
      push("halt_wb10_mask", SEL_MASK, {16'd0, mdl_mask});
      cyc();

      drive_halt(4'd3);
      drive_wb(4'd8, 32'h0000_0088);
      cyc();
      idle();
      mdl_mask[3] = 1'b1;
      mdl_pc[8]   = 12'h088;
      i_thread_index_counter = 4'd8;
      push("halt3_wb8_mask", SEL_MASK, {16'd0, mdl_mask});
      push("halt3_wb8_pc", SEL_PC, 32'h0000_0088);
      cyc();

      // Asynchronous reset mid-run, with threads 3 and 10 parked.
      reset = 1'b1;
      push("mid_rst_rdy", SEL_RDY, 32'd0);
      push("mid_rst_mask", SEL_MASK, 32'd0);
      push("mid_rst_act", SEL_ACT, 32'd0);
      cyc();
      reset = 1'b0;
      drive_resume(4'd4, 32'h0000_0AAA);
      drive_halt(4'd11);
      drive_wb(4'd12, 32'h0000_0999);
      init_phase("reinit");
      idle();
      for (int t = 0; t < 16; t++) mdl_pc[t] = 12'h000;
      mdl_mask = '0;
      push("reinit_ready", SEL_RDY, 32'd1);
      push("reinit_mask", SEL_MASK, 32'd0);
      cyc();
      sweep("reinit");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_file_mt.md
Name: pc_file_mt

Overview:
- Per-thread program-counter store for the barrel-threaded core, replacing the fixed 12-bit, always-on PC register vector.
- Holds one PC per hardware thread in distributed RAM and sequences start-up initialisation.
- Gates execute-stage write-back during pipeline warm-up.
- Adds per-thread halt/resume with PC redirect, so the fetch stage can skip parked threads.

Parameters:
DWIDTH, 32, width of PC ports
PC_BITS, 12, stored PC bits per thread (1..DWIDTH); upper bits are zero-extended on read
NUM_THREADS, 16, number of hardware threads (power of two, >=2)
EXE_STAGE, 7, pipeline index of execute stage; sets warm-up length
STARTUP_ADDR, riscv_pkg STARTUP_ADDR, PC loaded into every thread at init

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
i_thread_index_counter  in  TW=$clog2(NUM_THREADS)  fetch-stage thread being read
o_pcreg_out  out  DWIDTH  PC of i_thread_index_counter, zero-extended
o_thread_active  out  1  1 when the read thread is not halted and o_ready=1
o_ready  out  1  init finished; fetch may trust o_pcreg_out
i_wb_valid  in  1  execute stage presents a next-PC
i_wb_thread  in  TW  thread of the write-back
i_pc_in  in  DWIDTH  next PC; bits [PC_BITS-1:0] are stored
i_halt_valid  in  1  park thread i_halt_thread
i_halt_thread  in  TW  thread to halt
i_resume_valid  in  1  restart thread i_resume_thread
i_resume_thread  in  TW  thread to resume
i_resume_pc  in  DWIDTH  PC loaded on resume
o_halted_mask  out  NUM_THREADS  bit t = thread t halted

Behaviour:
- State machine: INIT -> WARMUP -> RUN.
- Async reset:
  - State=INIT, init pointer=0, warm-up counter=0, halted mask=0.
  - Outputs: o_ready=0, o_thread_active=0, o_halted_mask=0.
  - Reset asserted mid-operation aborts everything immediately. RAM contents are not reset; the INIT state rewrites them.
- INIT:
  - One RAM write per cycle: addr = init pointer, data = STARTUP_ADDR[PC_BITS-1:0].
  - Pointer increments each cycle. After writing entry NUM_THREADS-1, go to WARMUP (NUM_THREADS cycles total).
  - All wb/halt/resume inputs are ignored.
- WARMUP:
  - Lasts EXE_STAGE+1 cycles; counter compares against EXE_STAGE+1 at TW+1 bits to avoid truncation.
  - o_ready=1 from the first WARMUP cycle.
  - wb writes are ignored (pipeline still holds bubbles). Halt and resume are honoured.
- RUN:
  - i_wb_valid=1 writes i_pc_in[PC_BITS-1:0] to entry i_wb_thread on the clock edge, unless that thread is halted, or is being halted or resumed in the same cycle.
- Read path:
  - Asynchronous RAM read at i_thread_index_counter.
  - Write-first bypass: if a write to the same address is performed in the same cycle, o_pcreg_out shows the write data combinationally.
  - Zero-extension to DWIDTH.
- Halt:
  - Sets bit i_halt_thread in the mask at the edge.
  - o_thread_active for that thread is 0 from the next cycle. The stored PC is frozen.
- Resume:
  - Writes i_resume_pc to entry i_resume_thread and clears its mask bit at the edge.
  - Resume of a non-halted thread is a plain redirect (PC overwrite).
- Simultaneous events:
  - Priority: resume > halt > wb.
  - Halt and resume on the same thread in one cycle: resume wins (thread running, PC = i_resume_pc).
  - Resume and wb on different threads in one cycle: one RAM write port only. Resume is written and the wb is dropped. wb to a thread other than a halted one is otherwise always performed.
- Single write port. The write mux selects in order: init, resume, wb.

Decomposition:
- riscv_pkg:
  - Add pcf_state_t enum {PCF_INIT, PCF_WARMUP, PCF_RUN}.
  - STARTUP_ADDR stays there.
- Sub-module: reuse the existing LUT_RAM (depth NUM_THREADS, addr TW, data PC_BITS). The bypass and control logic stay in pc_file_mt.

Test Plan:
- Reset, NUM_THREADS=16, STARTUP_ADDR=0x000 -> o_ready=0 for 16 cycles, then 1. Sweeping the read index returns 0x00000000 for all 16 threads.
- 3 cycles after o_ready, wb thread 5 pc=0x0000_0ABC (within warm-up) -> entry 5 still 0x000. Same write after WARMUP ends -> read 5 returns 0x00000ABC. i_pc_in=0xFFFF_F123 stores 0x123.
- In RUN, read index=9 with wb thread 9 pc=0x444 in the same cycle -> o_pcreg_out=0x00000444 in that cycle (bypass).
- Halt thread 3 -> o_halted_mask=0x0008 and o_thread_active=0 when reading 3. wb to 3 with pc=0x100 is ignored. Resume 3 with pc=0x200 -> mask=0, read 3=0x200.
- Same cycle: halt 7 + resume 7 pc=0x0F0 -> mask bit 7=0, PC 0x0F0. Resume 2 pc=0x010 + wb 4 pc=0x020 -> entry 2=0x010, entry 4 unchanged.
- Assert reset mid-RUN while thread 3 is halted -> next cycle o_ready=0 and mask=0. After 16 cycles all entries=STARTUP_ADDR.
